// File: rtl/btn_event_capture.sv
// btn_event_capture: synchronise, debounce and latch button presses as sticky pending events; define BTN_CAPTURE_OVF_EN for lost-press flags
module btn_event_capture #(
  parameter int N_BTN  = 4,
  parameter int DB_CNT = 1000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             ack,
  input  logic [N_BTN-1:0] ack_mask,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] ovf,
  output logic             irq
);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_CNT - 1);
  logic [N_BTN-1:0] meta_q, sync_q, level_q, level_d, pending_q, pending_d, hit, press, clr;
  logic [CW-1:0] cnt_q [N_BTN];
  logic [CW-1:0] cnt_d [N_BTN];
  logic irq_q, irq_d;
  always_comb begin
    hit   = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      hit[i]   = sync_q[i] != level_q[i] && cnt_q[i] == CMAX;
      cnt_d[i] = (sync_q[i] == level_q[i] || hit[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    level_d   = level_q ^ hit;
    press     = level_d & ~level_q;
    clr       = ack ? ack_mask : '0;
    pending_d = press | (pending_q & ~clr);
    irq_d     = |pending_d;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
      cnt_q     <= '{default: '0};
    end else begin
      meta_q    <= btn_raw;
      sync_q    <= meta_q;
      level_q   <= level_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      cnt_q     <= cnt_d;
    end
`ifdef BTN_CAPTURE_OVF_EN
  logic [N_BTN-1:0] ovf_q, ovf_d;
  // a press onto an already-pending bit flags a lost event even if that bit is being acked
  always_comb ovf_d = (press & pending_q) | (ovf_q & ~clr);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_q <= '0;
    else ovf_q <= ovf_d;
  assign ovf = ovf_q;
`else
  assign ovf = '0;
`endif
  assign level   = level_q;
  assign pending = pending_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_btn_event_capture.sv
// tb_btn_event_capture: directed checks of sync/debounce latency, sticky pending, ack priority, overflow and async reset
module tb_btn_event_capture;
`ifdef BTN_CAPTURE_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic       ack = 1'b0;
  logic [3:0] ack_mask = '0;
  logic [3:0] level, pending, ovf;
  logic       irq;
  int n_chk = 0;
  int n_fail = 0;

  btn_event_capture #(.N_BTN(4), .DB_CNT(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw), .ack(ack), .ack_mask(ack_mask),
    .level(level), .pending(pending), .ovf(ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack(input logic [3:0] m);
    ack = 1'b1;
    ack_mask = m;
    tick(1);
    ack = 1'b0;
    ack_mask = '0;
  endtask

  task automatic test_reset;
    tick(2);
    n_chk++; if ({level, pending, ovf, irq} !== 13'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", {level, pending, ovf, irq}); end
    reset_n = 1'b1;
    tick(20);
    n_chk++; if (level !== 4'b0000) begin n_fail++; $display("FAIL idle_level: got %b want 0000", level); end
    n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL idle_pending: got %b want 0000", pending); end
    n_chk++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL idle_ovf: got %b want 0000", ovf); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL idle_irq: got %b want 0", irq); end
  endtask

  task automatic test_press;
    btn_raw = 4'b0010;
    tick(5);
    n_chk++; if (level !== 4'b0000) begin n_fail++; $display("FAIL press_early: got %b want 0000", level); end
    n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_early: got %b want 0", irq); end
    tick(1);
    n_chk++; if (level !== 4'b0010) begin n_fail++; $display("FAIL press_level: got %b want 0010", level); end
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL press_pending: got %b want 0010", pending); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq: got %b want 1", irq); end
    tick(14);
    btn_raw = 4'b0000;
    tick(5);
    n_chk++; if (level !== 4'b0010) begin n_fail++; $display("FAIL release_early: got %b want 0010", level); end
    tick(1);
    n_chk++; if (level !== 4'b0000) begin n_fail++; $display("FAIL release_level: got %b want 0000", level); end
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL release_pending: got %b want 0010", pending); end
    pulse_ack(4'b0010);
    n_chk++; if ({pending, irq} !== 5'b0) begin n_fail++; $display("FAIL ack_clear: got %b want 00000", {pending, irq}); end
  endtask

  task automatic test_glitch;
    int rises = 0;
    logic prev;
    btn_raw = 4'b0001;
    tick(3);
    btn_raw = 4'b0000;
    tick(10);
    n_chk++; if (level !== 4'b0000) begin n_fail++; $display("FAIL glitch_level: got %b want 0000", level); end
    n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL glitch_pending: got %b want 0000", pending); end
    prev = level[0];
    btn_raw = 4'b0001;
    tick(1);
    btn_raw = 4'b0000;
    tick(1);
    btn_raw = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (level[0] && !prev) rises++;
      prev = level[0];
    end
    n_chk++; if (rises !== 1) begin n_fail++; $display("FAIL chatter_events: got %0d want 1", rises); end
    n_chk++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL chatter_pending: got %b want 0001", pending); end
    btn_raw = 4'b0000;
    tick(10);
    pulse_ack(4'b0001);
    n_chk++; if ({level, pending} !== 8'b0) begin n_fail++; $display("FAIL chatter_clear: got %b want 0", {level, pending}); end
  endtask

  task automatic test_ack_collision;
    btn_raw = 4'b0010;
    tick(6);
    btn_raw = 4'b0000;
    tick(8);
    pulse_ack(4'b0000);
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ack_zero_mask: got %b want 0010", pending); end
    pulse_ack(4'b0101);
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL ack_other_bits: got %b want 0010", pending); end
    btn_raw = 4'b0010;
    tick(5);
    ack = 1'b1;
    ack_mask = 4'b0011;
    tick(1);
    ack = 1'b0;
    ack_mask = '0;
    n_chk++; if (level !== 4'b0010) begin n_fail++; $display("FAIL collide_level: got %b want 0010", level); end
    n_chk++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL collide_pending: got %b want 0010", pending); end
    n_chk++; if (ovf !== (OVF ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL collide_ovf: got %b want %b", ovf, OVF ? 4'b0010 : 4'b0000); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_irq: got %b want 1", irq); end
    pulse_ack(4'b0010);
    n_chk++; if ({pending, ovf, irq} !== 9'b0) begin n_fail++; $display("FAIL collide_clear: got %b want 0", {pending, ovf, irq}); end
    btn_raw = 4'b0000;
    tick(10);
  endtask

  task automatic test_back_to_back;
    btn_raw = 4'b1000;
    tick(6);
    n_chk++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL b2b_first: got %b want 1000", pending); end
    n_chk++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL b2b_first_ovf: got %b want 0000", ovf); end
    btn_raw = 4'b0000;
    tick(8);
    btn_raw = 4'b1000;
    tick(6);
    n_chk++; if (pending !== 4'b1000) begin n_fail++; $display("FAIL b2b_pending: got %b want 1000", pending); end
    n_chk++; if (ovf !== (OVF ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL b2b_ovf: got %b want %b", ovf, OVF ? 4'b1000 : 4'b0000); end
    btn_raw = 4'b0000;
    tick(8);
    pulse_ack(4'b1000);
    n_chk++; if ({pending, ovf, irq} !== 9'b0) begin n_fail++; $display("FAIL b2b_clear: got %b want 0", {pending, ovf, irq}); end
  endtask

  task automatic test_reset_mid;
    btn_raw = 4'b0001;
    tick(6);
    n_chk++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL mid_setup: got %b want 0001", pending); end
    btn_raw = 4'b0101;
    tick(4);
    reset_n = 1'b0;
    #1;
    n_chk++; if ({level, pending, ovf, irq} !== 13'b0) begin n_fail++; $display("FAIL mid_async: got %b want 0", {level, pending, ovf, irq}); end
    tick(1);
    reset_n = 1'b1;
    tick(5);
    n_chk++; if (level !== 4'b0000) begin n_fail++; $display("FAIL mid_early: got %b want 0000", level); end
    tick(1);
    n_chk++; if (level !== 4'b0101) begin n_fail++; $display("FAIL mid_level: got %b want 0101", level); end
    n_chk++; if (pending !== 4'b0101) begin n_fail++; $display("FAIL mid_pending: got %b want 0101", pending); end
    n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq: got %b want 1", irq); end
    btn_raw = 4'b0000;
    tick(8);
  endtask

  initial begin
    test_reset;
    test_press;
    test_glitch;
    test_ack_collision;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
